// File: rtl/exnor_bist_pkg.sv
// Shared types and constants for the XNOR gate BIST controller.
package exnor_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  localparam int NUM_VEC = 4;

  // Expected gate output, bit i for vector i = {a,b}.
  localparam logic [NUM_VEC-1:0] EXP_TT = 4'b1001;

  function automatic logic exp_c(
    input logic [1:0] vec
  );
    return EXP_TT[vec];
  endfunction

endpackage

// File: rtl/exnor_bist_ctrl.sv
// BIST controller sweeping all four {a,b} vectors over an external XNOR gate.
// Optional first-failure log enabled by EXNOR_BIST_ERRLOG_EN.
module exnor_bist_ctrl
  import exnor_bist_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int PASSES     = 1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
`ifdef EXNOR_BIST_ERRLOG_EN
  ,
  output logic [1:0]       err_vec,
  output logic             err_valid
`endif
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(SETTLE_CYC - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);
  localparam logic [1:0]    VEC_LAST  = 2'(NUM_VEC - 1);

  state_e           state_q;
  logic [1:0]       vec_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    pidx_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             miss;
  logic             accept;

  assign accept = (state_q == IDLE) && start;

  always_comb begin
    miss  = (c != exp_c(vec_q));
    err_d = err_q;
    if (miss && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      pidx_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETTLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            pidx_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        SAMPLE: begin
          err_q <= err_d;
          if ((vec_q == VEC_LAST) && (pidx_q == PASS_LAST)) begin
            state_q <= DONE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            // vec wraps 3 -> 0 naturally at the end of a sweep
            if (vec_q == VEC_LAST) begin
              pidx_q <= pidx_q + PW'(1);
            end
            vec_q   <= vec_q + 2'd1;
            state_q <= SETTLE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a       = vec_q[1];
  assign b       = vec_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;

`ifdef EXNOR_BIST_ERRLOG_EN
  logic [1:0] ev_q;
  logic       evld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q   <= '0;
      evld_q <= 1'b0;
    end else if (accept) begin
      ev_q   <= '0;
      evld_q <= 1'b0;
    end else if ((state_q == SAMPLE) && miss && !evld_q) begin
      ev_q   <= vec_q;
      evld_q <= 1'b1;
    end
  end

  assign err_vec   = ev_q;
  assign err_valid = evld_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_exnor_bist_ctrl.sv
// Bench for exnor_bist_ctrl: run-index model checked every cycle on two
// instances (defaults, and PASSES=3/ERR_W=3), plus literal expectations.
module tb_exnor_bist_ctrl;

  localparam int S0 = 2;
  localparam int P0 = 1;
  localparam int W0 = 8;
  localparam int S1 = 2;
  localparam int P1 = 3;
  localparam int W1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] st = '0;
  logic [1:0] rnd = '0;
  int mode [2] = '{0, 0};

  int S [2] = '{S0, S1};
  int P [2] = '{P0, P1};
  int EMAX [2] = '{(1 << W0) - 1, (1 << W1) - 1};

  int checks = 0;
  int errors = 0;

  // model state: t = cycle within run (0 = not running)
  int t [2];
  int err [2];
  int pv [2];
  int ev [2];
  int evv [2];

  logic a0, b0, c0, busy0, done0, pass0;
  logic [W0-1:0] ec0;
  logic a1, b1, c1, busy1, done1, pass1;
  logic [W1-1:0] ec1;
  logic [1:0] ev0, ev1;
  logic evd0, evd1;

  function automatic logic gate(int m, logic x, logic y, logic r);
    case (m)
      0: return ~(x ^ y);
      1: return 1'b0;
      2: return x ^ y;
      default: return r;
    endcase
  endfunction

  assign c0 = gate(mode[0], a0, b0, rnd[0]);
  assign c1 = gate(mode[1], a1, b1, rnd[1]);

`ifndef EXNOR_BIST_ERRLOG_EN
  assign ev0 = '0;
  assign ev1 = '0;
  assign evd0 = 1'b0;
  assign evd1 = 1'b0;
`endif

  exnor_bist_ctrl #(
    .SETTLE_CYC(S0), .PASSES(P0), .ERR_W(W0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]),
    .a(a0), .b(b0), .c(c0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(ec0)
`ifdef EXNOR_BIST_ERRLOG_EN
    , .err_vec(ev0), .err_valid(evd0)
`endif
  );

  exnor_bist_ctrl #(
    .SETTLE_CYC(S1), .PASSES(P1), .ERR_W(W1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]),
    .a(a1), .b(b1), .c(c1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(ec1)
`ifdef EXNOR_BIST_ERRLOG_EN
    , .err_vec(ev1), .err_valid(evd1)
`endif
  );

  always #5 clk = ~clk;

  function automatic int run_len(int i);
    return P[i] * 4 * (S[i] + 1);
  endfunction

  function automatic int vof(int i, int tt);
    if (tt >= 1 && tt <= run_len(i)) return ((tt - 1) / (S[i] + 1)) % 4;
    return 0;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(int i);
    int L;
    int v;
    logic cv;
    L = run_len(i);
    if (t[i] == 0) begin
      if (st[i]) begin
        t[i] = 1; err[i] = 0; pv[i] = 0; ev[i] = 0; evv[i] = 0;
      end
    end else if (t[i] <= L) begin
      if (t[i] % (S[i] + 1) == 0) begin
        v = vof(i, t[i]);
        cv = gate(mode[i], v[1], v[0], rnd[i]);
        if (cv != ((v == 0) || (v == 3))) begin
          if (err[i] < EMAX[i]) err[i]++;
          if (evv[i] == 0) begin evv[i] = 1; ev[i] = v; end
        end
      end
      if (t[i] == L) pv[i] = (err[i] == 0);
      t[i]++;
    end else begin
      t[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        t[i] = 0; err[i] = 0; pv[i] = 0; ev[i] = 0; evv[i] = 0;
      end else begin
        step(i);
      end
    end
  end

  task automatic cmp(int i, logic a, logic b, logic bz, logic dn,
                     logic ps, int ec, int evo, int evdo);
    int L;
    int eb;
    L = run_len(i);
    eb = (t[i] >= 1 && t[i] <= L) ? 1 : 0;
    chk($sformatf("busy%0d", i), int'(bz), eb);
    chk($sformatf("ab%0d", i), int'({a, b}), vof(i, t[i]));
    chk($sformatf("done%0d", i), int'(dn), (t[i] == L + 1) ? 1 : 0);
    chk($sformatf("err_cnt%0d", i), ec, err[i]);
    chk($sformatf("pass%0d", i), int'(ps), pv[i]);
`ifdef EXNOR_BIST_ERRLOG_EN
    chk($sformatf("err_vec%0d", i), evo, ev[i]);
    chk($sformatf("err_valid%0d", i), evdo, evv[i]);
`else
    if (evo != 0 || evdo != 0) chk("errlog_absent", evo + evdo, 0);
`endif
  endtask

  always @(negedge clk) begin
    cmp(0, a0, b0, busy0, done0, pass0, int'(ec0), int'(ev0), int'(evd0));
    cmp(1, a1, b1, busy1, done1, pass1, int'(ec1), int'(ev1), int'(evd1));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic done_of(int i);
    return (i == 0) ? done0 : done1;
  endfunction

  // pulse start, return the cycle number in which done is observed
  task automatic run_measure(int i, output int dc);
    st[i] = 1'b1;
    tick();
    st[i] = 1'b0;
    dc = -1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (done_of(i)) begin
        dc = n;
        break;
      end
      tick();
    end
    if (dc < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int dc;
    int nd;
    int df;
    int r2;

    // reset held with start high
    st = 2'b11;
    repeat (4) tick();
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_busy1", int'(busy1), 0);
    st = '0;
    rst_n = 1'b1;
    tick();

    mode[0] = 0;
    run_measure(0, dc);
    chk("good_len", dc, 13);
    chk("good_pass", int'(pass0), 1);
    chk("good_err", int'(ec0), 0);
    tick();

    mode[0] = 1;
    run_measure(0, dc);
    chk("stuck_len", dc, 13);
    chk("stuck_err", int'(ec0), 2);
    chk("stuck_pass", int'(pass0), 0);
`ifdef EXNOR_BIST_ERRLOG_EN
    chk("stuck_ev", int'(ev0), 0);
    chk("stuck_evd", int'(evd0), 1);
`endif
    tick();

    mode[1] = 2;
    run_measure(1, dc);
    chk("xor_len", dc, 37);
    chk("xor_err", int'(ec1), 7);
    chk("xor_pass", int'(pass1), 0);
    tick();

    // extra start pulses mid-run and in the done cycle
    mode[0] = 0;
    st[0] = 1'b1;
    tick();
    nd = 0;
    df = 0;
    for (int n = 1; n <= 30; n++) begin
      st[0] = (n == 5) || (n == 13);
      @(negedge clk);
      if (done0) begin
        nd++;
        if (df == 0) df = n;
      end
      tick();
    end
    st[0] = 1'b0;
    chk("one_done", nd, 1);
    chk("pulse_len", df, 13);

    // start held high: back-to-back runs with one idle cycle
    st[0] = 1'b1;
    tick();
    df = 0;
    r2 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done0 && df == 0) df = n;
      if (df != 0 && n > df && busy0 && r2 == 0) r2 = n;
      tick();
    end
    st[0] = 1'b0;
    chk("held_gap", r2 - df, 2);
    repeat (20) tick();

    // abort in cycle 6
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (5) tick();
    chk("pre_abort_busy", int'(busy0), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_ab", int'({a0, b0}), 0);
    chk("abort_done", int'(done0), 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_measure(0, dc);
    chk("rerun_len", dc, 13);
    chk("rerun_pass", int'(pass0), 1);
    tick();

    // randomized gates and start requests
    for (int n = 0; n < 1500; n++) begin
      if (n % 60 == 0) begin
        mode[0] = $urandom_range(0, 3);
        mode[1] = $urandom_range(0, 3);
      end
      rnd = 2'($urandom);
      st[0] = ($urandom_range(0, 7) == 0);
      st[1] = ($urandom_range(0, 7) == 0);
      tick();
    end
    st = '0;
    repeat (60) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
